regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 4, address width; DEPTH = 2**ADDR_BITS entries.
REQ-003 SHALL have parameter ZERO_R0, default 0, where 1 makes entry 0 read-only zero.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clr  input  1  request a full-array clear sweep.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  ADDR_BITS  write address.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have ports re_a / re_b  input  1  read enable, port A / port B.
REQ-011 SHALL have ports raddr_a / raddr_b  input  ADDR_BITS  read address, port A / port B.
REQ-012 SHALL have ports rdata_a / rdata_b  output  WIDTH  registered read data.
REQ-013 SHALL have ports rvalid_a / rvalid_b  output  1  one-cycle pulse marking new rdata.
REQ-014 SHALL have port busy  output  1  high while clear sweep active; writes and reads refused.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR (sweep index idx 0..DEPTH-1) and IDLE.
REQ-016 In CLEAR: each cycle SHALL write 0 to mem[idx], then idx+1; at idx==DEPTH-1, write 0 and go IDLE next edge.
REQ-017 Sweep SHALL take exactly DEPTH cycles; busy SHALL be 1 throughout CLEAR, 0 in IDLE.
REQ-018 In IDLE, clr==1 at an edge SHALL enter CLEAR with idx=0; busy high from that edge.
REQ-019 clr during CLEAR SHALL be ignored; the sweep neither restarts nor extends.
REQ-020 In IDLE, we==1 SHALL write wdata to mem[waddr] at the edge, except when clr==1 the same cycle (write dropped).
REQ-021 With ZERO_R0==1, writes to address 0 SHALL be dropped and reads of address 0 SHALL return 0.
REQ-022 In IDLE, re_x==1 SHALL load rdata_x with mem[raddr_x] and set rvalid_x=1 at the edge; latency one cycle.
REQ-023 re_x==0, or any cycle in CLEAR, SHALL hold rdata_x unchanged and set rvalid_x=0.
REQ-024 Read and write of the same address in the same IDLE cycle SHALL return wdata (write-first bypass), subject to REQ-021.
REQ-025 Both read ports SHALL operate independently; the same address on both SHALL return identical data.
REQ-026 Read/write requests in CLEAR SHALL be discarded, not queued; callers retry once busy==0.
REQ-027 Addresses SHALL cover all DEPTH entries with no aliasing; no out-of-range condition exists.

Reset
REQ-028 rst_n==0 SHALL immediately force: state CLEAR, idx=0, busy=1, rdata_a=rdata_b=0, rvalid_a=rvalid_b=0.
REQ-029 The array SHALL NOT be reset directly; after rst_n rises, the sweep SHALL zero it in DEPTH cycles.
REQ-030 rst_n asserted mid-sweep or mid-access SHALL abort that operation and restart per REQ-028.

Verification
REQ-031 Reset release, DEPTH=16 -> busy high exactly 16 cycles; then read every address -> rdata 0, rvalid pulses 1 cycle.
REQ-032 IDLE: we=1, waddr=5, wdata=16'hBEEF; next cycle re_a=1, raddr_a=5 -> rdata_a=16'hBEEF, rvalid_a=1 one cycle later.
REQ-033 Same cycle: we=1, waddr=3, wdata=16'h1234, re_a=re_b=1, raddr_a=raddr_b=3 -> both rdata=16'h1234 next cycle (bypass).
REQ-034 Fill entries 0..15 with value idx+1, assert clr with we=1, waddr=2, wdata=16'hFFFF -> busy 16 cycles, write dropped, all reads 0 afterwards; clr pulse mid-sweep does not extend busy.
REQ-035 ZERO_R0=1: write 16'hAAAA to address 0, read address 0 -> rdata=0; read during busy -> rvalid=0, rdata held.
REQ-036 Drop rst_n at sweep idx=7 -> outputs reset at once; after release, busy high a full 16 cycles.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two-read one-write register file with a self-clearing sweep
module regfile_2r1w #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter bit ZERO_R0   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re_a,
  input  logic                 re_b,
  input  logic [ADDR_BITS-1:0] raddr_a,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [WIDTH-1:0]     rdata_a,
  output logic [WIDTH-1:0]     rdata_b,
  output logic                 rvalid_a,
  output logic                 rvalid_b,
  output logic                 busy
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t               state, state_nx;
  logic [ADDR_BITS-1:0] idx, idx_nx;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 wr_en;
  logic [WIDTH-1:0]     rd_a, rd_b;
  assign busy  = state == CLEAR;
  assign wr_en = !busy && we && !clr && !(ZERO_R0 && waddr == '0);
  assign rd_a  = (ZERO_R0 && raddr_a == '0) ? '0 : (wr_en && waddr == raddr_a) ? wdata : mem[raddr_a];
  assign rd_b  = (ZERO_R0 && raddr_b == '0) ? '0 : (wr_en && waddr == raddr_b) ? wdata : mem[raddr_b];
  // state and sweep index register; reset restarts the sweep from entry 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end
  // sweep advances one entry per cycle; clr only honoured while idle
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (busy) begin
      idx_nx   = idx + 1'b1;
      state_nx = &idx ? IDLE : CLEAR;
    end else if (clr) begin
      state_nx = CLEAR;
      idx_nx   = '0;
    end
  end
  // storage array: sweep zeroes one entry per cycle, otherwise accepted writes
  always_ff @(posedge clk) begin
    if (busy) mem[idx] <= '0;
    else if (wr_en) mem[waddr] <= wdata;
  end
  // registered read ports with write-first bypass; data held when not reading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= !busy && re_a;
      rvalid_b <= !busy && re_b;
      if (!busy && re_a) rdata_a <= rd_a;
      if (!busy && re_b) rdata_b <= rd_b;
    end
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed self-checking bench for regfile_2r1w
module tb_regfile_2r1w;
  logic        clk = 0, rst_n = 0, clr = 0, we = 0, re_a = 0, re_b = 0;
  logic [3:0]  waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [15:0] wdata = 0;
  logic [15:0] rdata_a, rdata_b, z_rdata_a, z_rdata_b;
  logic        rvalid_a, rvalid_b, busy, z_rvalid_a, z_rvalid_b, z_busy;
  int checks = 0, errors = 0;

  regfile_2r1w #(.WIDTH(16), .ADDR_BITS(4), .ZERO_R0(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .busy(busy));

  regfile_2r1w #(.WIDTH(16), .ADDR_BITS(4), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(z_rdata_a), .rdata_b(z_rdata_b), .rvalid_a(z_rvalid_a), .rvalid_b(z_rvalid_b), .busy(z_busy));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    we = 1; waddr = a; wdata = d;
    tick;
    we = 0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 40) begin tick; n++; end
  endtask

  task automatic test_reset;
    int n;
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
    checks++; if (rdata_a !== 16'h0 || rdata_b !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0000/0000", rdata_a, rdata_b); end
    checks++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b/%b exp 0/0", rvalid_a, rvalid_b); end
    repeat (2) tick;
    rst_n = 1;
    wait_sweep(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL reset_sweep_len got %0d exp 16", n); end
    checks++; if (z_busy !== 1'b0) begin errors++; $display("FAIL reset_sweep_z got %b exp 0", z_busy); end
    for (int a = 0; a < 16; a++) begin
      re_a = 1; re_b = 1; raddr_a = 4'(a); raddr_b = 4'(15 - a);
      tick;
      checks++; if (rdata_a !== 16'h0 || rdata_b !== 16'h0 || rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin errors++; $display("FAIL reset_read_%0d got %h/%h v%b%b exp 0000/0000 v11", a, rdata_a, rdata_b, rvalid_a, rvalid_b); end
    end
    re_a = 0; re_b = 0;
    tick;
    checks++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL reset_rvalid_pulse got %b/%b exp 0/0", rvalid_a, rvalid_b); end
  endtask

  task automatic test_write_read;
    do_write(4'd5, 16'hBEEF);
    re_a = 1; raddr_a = 4'd5;
    tick;
    re_a = 0;
    checks++; if (rdata_a !== 16'hBEEF || rvalid_a !== 1'b1) begin errors++; $display("FAIL wr_rd got %h v%b exp beef v1", rdata_a, rvalid_a); end
    tick;
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_hold got %h v%b exp beef v0", rdata_a, rvalid_a); end
  endtask

  task automatic test_bypass;
    we = 1; waddr = 4'd3; wdata = 16'h1234;
    re_a = 1; re_b = 1; raddr_a = 4'd3; raddr_b = 4'd3;
    tick;
    we = 0; re_a = 0; re_b = 0;
    checks++; if (rdata_a !== 16'h1234 || rdata_b !== 16'h1234) begin errors++; $display("FAIL bypass got %h/%h exp 1234/1234", rdata_a, rdata_b); end
    re_b = 1; raddr_b = 4'd5;
    tick;
    re_b = 0;
    checks++; if (rdata_b !== 16'hBEEF || rdata_a !== 16'h1234) begin errors++; $display("FAIL indep_ports got %h/%h exp 1234/beef", rdata_a, rdata_b); end
  endtask

  task automatic test_clear;
    int n;
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'(i + 1));
    for (int i = 0; i < 16; i++) begin
      re_a = 1; re_b = 1; raddr_a = 4'(i); raddr_b = 4'(15 - i);
      tick;
      checks++; if (rdata_a !== 16'(i + 1) || rdata_b !== 16'(16 - i)) begin errors++; $display("FAIL fill_%0d got %h/%h exp %h/%h", i, rdata_a, rdata_b, 16'(i + 1), 16'(16 - i)); end
    end
    re_a = 0; re_b = 0;
    clr = 1; we = 1; waddr = 4'd2; wdata = 16'hFFFF;
    tick;
    clr = 0; we = 0;
    n = 0;
    while (busy && n < 40) begin clr = (n == 5); tick; n++; end
    clr = 0;
    checks++; if (n !== 16) begin errors++; $display("FAIL clr_len got %0d exp 16", n); end
    for (int i = 0; i < 16; i++) begin
      re_a = 1; re_b = 1; raddr_a = 4'(i); raddr_b = 4'(15 - i);
      tick;
      checks++; if (rdata_a !== 16'h0 || rdata_b !== 16'h0) begin errors++; $display("FAIL clr_read_%0d got %h/%h exp 0000/0000", i, rdata_a, rdata_b); end
    end
    re_a = 0; re_b = 0;
  endtask

  task automatic test_zero_r0;
    int n;
    do_write(4'd0, 16'hAAAA);
    re_a = 1; re_b = 1; raddr_a = 4'd0; raddr_b = 4'd0;
    tick;
    re_a = 0; re_b = 0;
    checks++; if (rdata_a !== 16'hAAAA) begin errors++; $display("FAIL r0_normal got %h exp aaaa", rdata_a); end
    checks++; if (z_rdata_a !== 16'h0 || z_rdata_b !== 16'h0 || z_rvalid_a !== 1'b1) begin errors++; $display("FAIL r0_zero got %h/%h v%b exp 0000/0000 v1", z_rdata_a, z_rdata_b, z_rvalid_a); end
    we = 1; waddr = 4'd0; wdata = 16'h5555; re_a = 1; raddr_a = 4'd0;
    tick;
    we = 0; re_a = 0;
    checks++; if (rdata_a !== 16'h5555 || z_rdata_a !== 16'h0) begin errors++; $display("FAIL r0_bypass got %h/%h exp 5555/0000", rdata_a, z_rdata_a); end
    do_write(4'd9, 16'h0909);
    re_b = 1; raddr_b = 4'd9;
    tick;
    re_b = 0;
    checks++; if (z_rdata_b !== 16'h0909) begin errors++; $display("FAIL r0_addr9 got %h exp 0909", z_rdata_b); end
    clr = 1;
    tick;
    clr = 0; re_a = 1; re_b = 1; raddr_a = 4'd9; raddr_b = 4'd9;
    we = 1; waddr = 4'd9; wdata = 16'h7E7E;
    tick;
    checks++; if (z_rvalid_b !== 1'b0 || z_rdata_b !== 16'h0909 || rvalid_a !== 1'b0) begin errors++; $display("FAIL busy_read got %h v%b%b exp 0909 v00", z_rdata_b, z_rvalid_b, rvalid_a); end
    re_a = 0; re_b = 0; we = 0;
    wait_sweep(n);
    re_b = 1;
    tick;
    re_b = 0;
    checks++; if (z_rdata_b !== 16'h0 || rdata_b !== 16'h0) begin errors++; $display("FAIL busy_write_drop got %h/%h exp 0000/0000", rdata_b, z_rdata_b); end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    do_write(4'd7, 16'h7777);
    re_a = 1; raddr_a = 4'd7;
    tick;
    re_a = 0;
    clr = 1;
    tick;
    clr = 0;
    repeat (7) tick;
    checks++; if (busy !== 1'b1 || rdata_a !== 16'h7777) begin errors++; $display("FAIL mid_hold got %h busy %b exp 7777 busy 1", rdata_a, busy); end
    rst_n = 0;
    #1;
    checks++; if (busy !== 1'b1 || rdata_a !== 16'h0 || rvalid_a !== 1'b0) begin errors++; $display("FAIL mid_reset got %h busy %b v%b exp 0000 busy 1 v0", rdata_a, busy, rvalid_a); end
    tick;
    rst_n = 1;
    wait_sweep(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL mid_reset_len got %0d exp 16", n); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_bypass;
    test_clear;
    test_zero_r0;
    test_reset_mid_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
